// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: state encoding and counter-width helper for the PLL reset sequencer
package pll_reset_pkg;
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, FILTER = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
  function automatic int cnt_width(input int f, input int h);
    return $clog2((f > h ? f : h) + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer; ports i_clk, i_rst (sync, high), i_d (async in), o_q (synced out)
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge i_clk)
    if (i_rst) {r_q, r_meta} <= 2'b00;
    else {r_q, r_meta} <= {r_meta, i_d};
  assign o_q = r_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: lock-qualified reset from PLL locked; ports clock, reset, locked_in, soft_reset -> reset_out, ready, lock_loss_count
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int FILTER_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 65536
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked_in,
  input  logic       soft_reset,
  output logic       reset_out,
  output logic       ready,
  output logic [7:0] lock_loss_count
);
  localparam int CW = cnt_width(FILTER_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] F_C = CW'(FILTER_CYCLES);
  localparam logic [CW-1:0] H_C = CW'(HOLD_CYCLES);
  logic w_locked_s;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [7:0] r_loss, w_loss;
  logic r_reset_out, r_ready;
  sync_2ff u_sync (
    .i_clk(clock),
    .i_rst(reset),
    .i_d  (locked_in),
    .o_q  (w_locked_s)
  );
  assign w_cnt_inc = r_cnt + 1'b1;
  // Counter defaults to clear; only the counting paths keep it moving.
  // FILTER compares the held count (entry already counted one sample), HOLD
  // compares the incremented count so RUN lands exactly HOLD_CYCLES edges after HOLD entry.
  always_comb begin
    w_state = r_state;
    w_cnt   = '0;
    w_loss  = r_loss;
    case (r_state)
      WAIT_LOCK: if (w_locked_s) begin
        w_state = FILTER;
        w_cnt   = CW'(1);
      end
      FILTER:
        if (!w_locked_s) w_state = WAIT_LOCK;
        else if (r_cnt == F_C) w_state = HOLD;
        else w_cnt = w_cnt_inc;
      HOLD:
        if (!w_locked_s) w_state = WAIT_LOCK;
        else if (soft_reset) w_cnt = '0;
        else if (w_cnt_inc == H_C) w_state = RUN;
        else w_cnt = w_cnt_inc;
      RUN:
        if (!w_locked_s) begin
          w_state = WAIT_LOCK;
          w_loss  = r_loss + {7'd0, r_loss != 8'hFF};
        end else if (soft_reset) w_state = HOLD;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_loss      <= '0;
      r_reset_out <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_loss      <= w_loss;
      r_reset_out <= w_state != RUN;
      r_ready     <= w_state == RUN;
    end
  assign reset_out       = r_reset_out;
  assign ready           = r_ready;
  assign lock_loss_count = r_loss;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: vector table, corner sequences and random stimulus against a lock-progress model
module tb_pll_reset_sequencer;
  import pll_reset_pkg::*;
  localparam int F = 4;
  localparam int H = 8;
  logic clock = 0, reset = 1, locked_in = 0, soft_reset = 0;
  logic reset_out, ready;
  logic [7:0] lock_loss_count;
  int errors = 0, checks = 0;
  bit m_s1, m_s2;
  int m_ok, m_since, m_loss;
  typedef struct {
    logic li, sr, rs;
    int n;
    logic ro;
    int loss;
    string name;
  } vec_t;
  vec_t tbl[11];
  pll_reset_sequencer #(.FILTER_CYCLES(F), .HOLD_CYCLES(H)) dut (
    .clock(clock),
    .reset(reset),
    .locked_in(locked_in),
    .soft_reset(soft_reset),
    .reset_out(reset_out),
    .ready(ready),
    .lock_loss_count(lock_loss_count)
  );
  always #5 clock = ~clock;
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // m_ok: consecutive edges with lock seen (capped at F+1); m_since: edges since
  // the hold period (re)started, -1 before qualification; output released once it reaches H.
  task automatic model_edge(input bit li, input bit sr, input bit rs);
    bit ls;
    if (rs) begin
      m_s1 = 0; m_s2 = 0; m_ok = 0; m_since = -1; m_loss = 0;
    end else begin
      ls = m_s2; m_s2 = m_s1; m_s1 = li;
      if (!ls) begin
        if (m_since >= H) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        m_ok = 0; m_since = -1;
      end else begin
        if (m_ok <= F) m_ok++;
        if (m_since < 0) begin
          if (m_ok == F + 1) m_since = 0;
        end else if (sr) m_since = 0;
        else if (m_since < H) m_since++;
      end
    end
  endtask
  task automatic tick(input bit li, input bit sr, input bit rs);
    locked_in = li; soft_reset = sr; reset = rs;
    @(posedge clock);
    model_edge(li, sr, rs);
    @(negedge clock);
    chk("model_reset_out", reset_out, (m_since >= H) ? 0 : 1);
    chk("model_ready", ready, (m_since >= H) ? 1 : 0);
    chk("model_loss", lock_loss_count, m_loss);
  endtask
  task automatic wait_fall(input string name, input int exp_edges);
    int n = 0;
    do begin
      tick(1, 0, 0);
      n++;
    end while (reset_out && n < 64);
    chk(name, n - 1, exp_edges);
  endtask
  task automatic high_until_fall(inout int hi);
    int n = 0;
    while (reset_out && n < 64) begin
      tick(1, 0, 0);
      if (reset_out) hi++;
      n++;
    end
  endtask
  initial begin
    int hi, prev, seg;
    bit li;
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 3,  1'b1, 0, "reset_hold"};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 14, 1'b1, 0, "lock_edge13"};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 0, "lock_edge14"};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5,  1'b0, 0, "run_steady"};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 0, "soft_rise"};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 7,  1'b1, 0, "soft_hold7"};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 0, "soft_fall"};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 0, "loss_sync"};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1, "loss_rise"};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 14, 1'b1, 1, "relock_edge13"};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1, "relock_edge14"};
    m_ok = 0; m_since = -1; m_loss = 0;
    for (int i = 0; i < 11; i++) begin
      repeat (tbl[i].n) tick(tbl[i].li, tbl[i].sr, tbl[i].rs);
      chk({tbl[i].name, "_reset_out"}, reset_out, tbl[i].ro);
      chk({tbl[i].name, "_ready"}, ready, !tbl[i].ro);
      chk({tbl[i].name, "_loss"}, lock_loss_count, tbl[i].loss);
    end
    chk("reset_out_ready_state", dut.r_state, RUN);
    hi = 0;
    tick(1, 1, 0);
    if (reset_out) hi++;
    high_until_fall(hi);
    chk("soft_single_len", hi, 8);
    hi = 0;
    tick(1, 1, 0);
    if (reset_out) hi++;
    repeat (5) begin
      tick(1, 0, 0);
      if (reset_out) hi++;
    end
    tick(1, 1, 0);
    if (reset_out) hi++;
    high_until_fall(hi);
    chk("soft_double_len", hi, 14);
    prev = lock_loss_count;
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("soft_drop_state", dut.r_state, WAIT_LOCK);
    chk("soft_drop_loss", lock_loss_count, prev + 1);
    chk("soft_drop_reset_out", reset_out, 1);
    wait_fall("soft_drop_relock_edges", 14);
    tick(0, 0, 1);
    tick(0, 0, 1);
    repeat (3) tick(1, 0, 0);
    repeat (6) tick(0, 0, 0);
    chk("glitch_state", dut.r_state, WAIT_LOCK);
    chk("glitch_reset_out", reset_out, 1);
    wait_fall("glitch_relock_edges", 14);
    tick(1, 1, 0);
    repeat (4) tick(1, 0, 0);
    chk("hold4_cnt", dut.r_cnt, 4);
    tick(1, 0, 1);
    chk("midhold_state", dut.r_state, WAIT_LOCK);
    chk("midhold_cnt", dut.r_cnt, 0);
    chk("midhold_loss", lock_loss_count, 0);
    chk("midhold_reset_out", reset_out, 1);
    wait_fall("midhold_relock_edges", 14);
    for (int k = 0; k < 260; k++) begin
      repeat (3) tick(0, 0, 0);
      wait_fall("sat_relock_edges", 14);
    end
    chk("sat_count", lock_loss_count, 255);
    tick(0, 0, 1);
    for (int k = 0; k < 150; k++) begin
      seg = $urandom_range(1, 30);
      li = $urandom_range(0, 3) != 0;
      repeat (seg) tick(li, $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
